gemm_acc_drain: RTL and testbench

Drains the systolic array's output rows into ACC SRAM, one INT32 element per write, ahead of GEMM post-processing. For each GEMM tile it accepts ARRAY_M row beats of ARRAY_N accumulators. It lays them out linearly at `base + row*ARRAY_N + col`, which is the order the post-processing stage reads back. In accumulate mode it performs a saturating read-modify-write so that partial sums from successive K-tiles add in place.

---
 rtl/gemm_acc_drain_if.sv | 36 +++
 rtl/gemm_acc_drain.sv | 125 ++++++++++++
 tb/tb_gemm_acc_drain.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_acc_drain_if.sv
// Handshake and ACC SRAM bus between the systolic-array drain and its neighbours.
// The slave modport is the drain itself; master is the upstream/SRAM side.
interface gemm_acc_drain_if #(
  parameter int ARRAY_N = 16,
  parameter int ACC_W   = 32
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_accum;
  logic [15:0]                cmd_base;
  logic                       row_valid;
  logic                       row_ready;
  logic [ARRAY_N*ACC_W-1:0]   row_data;
  logic                       acc_rd_en;
  logic [15:0]                acc_rd_addr;
  logic [ACC_W-1:0]           acc_rd_data;
  logic                       acc_rd_valid;
  logic                       acc_wr_en;
  logic [15:0]                acc_wr_addr;
  logic [ACC_W-1:0]           acc_wr_data;
  logic                       busy;
  logic                       done;
  logic                       ovf;

  modport master (
    output cmd_valid, cmd_accum, cmd_base, row_valid, row_data, acc_rd_data, acc_rd_valid,
    input  cmd_ready, row_ready, acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
           busy, done, ovf
  );

  modport slave (
    input  cmd_valid, cmd_accum, cmd_base, row_valid, row_data, acc_rd_data, acc_rd_valid,
    output cmd_ready, row_ready, acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
           busy, done, ovf
  );
endinterface

// File: rtl/gemm_acc_drain.sv
// Drains systolic-array row beats into ACC SRAM at base + row*ARRAY_N + col,
// either overwriting or doing a saturating read-modify-write per element.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for a command; cmd_ready high
//   ROW_WAIT   | waiting for the next row beat; row_ready high
//   RD         | issue ACC read of current element (accumulate only)
//   RMW_WAIT   | waiting for read data, then latch saturated sum
//   WR         | write current element, advance col/row
//   DONE       | one-cycle completion pulse
module gemm_acc_drain #(
  parameter int ARRAY_M = 16,
  parameter int ARRAY_N = 16,
  parameter int ACC_W   = 32
) (
  input logic             clk,
  input logic             rst,
  gemm_acc_drain_if.slave bus
);
  localparam int RW = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
  localparam int CW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_WAIT, S_RD, S_RMW_WAIT, S_WR, S_DONE
  } state_t;

  state_t                   state;
  logic [RW-1:0]            row_cnt;
  logic [CW-1:0]            col_cnt;
  logic [15:0]              base_q;
  logic                     accum_q;
  logic [ARRAY_N*ACC_W-1:0] row_buf;
  logic [ACC_W-1:0]         sum_q;
  logic                     ovf_q;

  logic [15:0]      elem_addr;
  logic [ACC_W-1:0] lane;
  logic [ACC_W:0]   wide_sum;
  logic             sat_hi;
  logic             sat_lo;
  logic [ACC_W-1:0] sat_sum;

  // 16-bit truncation gives the silent wrap past 0xFFFF
  assign elem_addr = base_q + 16'(int'(row_cnt) * ARRAY_N) + 16'(col_cnt);
  assign lane      = row_buf[col_cnt*ACC_W +: ACC_W];

  assign wide_sum = {bus.acc_rd_data[ACC_W-1], bus.acc_rd_data} + {lane[ACC_W-1], lane};
  assign sat_hi   = !wide_sum[ACC_W] &&  wide_sum[ACC_W-1];
  assign sat_lo   =  wide_sum[ACC_W] && !wide_sum[ACC_W-1];

  always_comb begin
    sat_sum = wide_sum[ACC_W-1:0];
    if (sat_hi)
      sat_sum = {1'b0, {(ACC_W-1){1'b1}}};
    else if (sat_lo)
      sat_sum = {1'b1, {(ACC_W-1){1'b0}}};
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.row_ready   = (state == S_ROW_WAIT);
  assign bus.acc_rd_en   = (state == S_RD);
  assign bus.acc_rd_addr = (state == S_RD) ? elem_addr : '0;
  assign bus.acc_wr_en   = (state == S_WR);
  assign bus.acc_wr_addr = (state == S_WR) ? elem_addr : '0;
  assign bus.acc_wr_data = (state != S_WR) ? '0 : (accum_q ? sum_q : lane);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);
  assign bus.ovf         = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      base_q  <= '0;
      accum_q <= 1'b0;
      row_buf <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            base_q  <= bus.cmd_base;
            accum_q <= bus.cmd_accum;
            row_cnt <= '0;
            col_cnt <= '0;
            ovf_q   <= 1'b0;
            state   <= S_ROW_WAIT;
          end
        end
        S_ROW_WAIT: begin
          if (bus.row_valid) begin
            row_buf <= bus.row_data;
            col_cnt <= '0;
            state   <= accum_q ? S_RD : S_WR;
          end
        end
        S_RD: state <= S_RMW_WAIT;
        S_RMW_WAIT: begin
          if (bus.acc_rd_valid) begin
            sum_q <= sat_sum;
            if (sat_hi || sat_lo)
              ovf_q <= 1'b1;
            state <= S_WR;
          end
        end
        S_WR: begin
          if (col_cnt != CW'(ARRAY_N - 1)) begin
            col_cnt <= col_cnt + 1'b1;
            state   <= accum_q ? S_RD : S_WR;
          end else if (row_cnt == RW'(ARRAY_M - 1)) begin
            state <= S_DONE;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= S_ROW_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_acc_drain.sv
// Self-checking bench for gemm_acc_drain: table of directed commands, random
// overwrite/accumulate pairs, and a mid-command reset, against an SRAM model.
module tb_gemm_acc_drain;
  localparam int M = 16;
  localparam int N = 16;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gemm_acc_drain_if #(.ARRAY_N(N), .ACC_W(W)) bus ();
  gemm_acc_drain #(.ARRAY_M(M), .ARRAY_N(N), .ACC_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;
  string cur_tag = "init";

  logic signed [W-1:0] mem     [65536];
  logic signed [W-1:0] ref_mem [65536];
  logic signed [W-1:0] lanes   [M][N];

  typedef struct { logic [15:0] addr; logic [W-1:0] data; } wr_t;
  wr_t exp_q[$];

  int accept_edge = 0;
  int n_wr, n_rd, n_done, first_wr_rel, done_rel;
  int rd_lat = 1;
  int rd_due;
  bit stray_en = 0, rd_pending = 0, chk_data_en = 0, rows_active = 0, abort_rows = 0;
  logic [15:0] rd_addr_q, wr8_addr;
  logic [W-1:0] chk_data;

  typedef struct {
    bit accum; logic [15:0] base; bit pat_rc; logic [W-1:0] val;
    int gap; int lat; bit stray; int exp_done; int exp_first; int exp_ovf;
    bit cde; logic [W-1:0] cdv; bit wrap;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // ACC SRAM model, read responder and write scoreboard
  initial begin
    wr_t e;
    bus.acc_rd_valid = 1'b0;
    bus.acc_rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.acc_rd_valid = 1'b0;
      bus.acc_rd_data  = '0;
      if (rst) begin
        rd_pending = 0;
      end else if (rd_pending && edge_n == rd_due) begin
        bus.acc_rd_valid = 1'b1;
        bus.acc_rd_data  = mem[rd_addr_q];
        rd_pending = 0;
      end else if (stray_en && !rd_pending && $urandom_range(0, 2) == 0) begin
        bus.acc_rd_valid = 1'b1;
        bus.acc_rd_data  = $urandom;
      end
      if (!bus.acc_rd_en) check("rd_addr_idle", bus.acc_rd_addr, 0);
      if (!bus.acc_wr_en) begin
        check("wr_addr_idle", bus.acc_wr_addr, 0);
        check("wr_data_idle", bus.acc_wr_data, 0);
      end
      if (bus.acc_rd_en) begin
        n_rd++;
        rd_pending = 1;
        rd_addr_q  = bus.acc_rd_addr;
        rd_due     = edge_n + rd_lat;
      end
      if (bus.acc_wr_en) begin
        if (n_wr == 0) first_wr_rel = edge_n + 1 - accept_edge;
        if (n_wr == 8) wr8_addr = bus.acc_wr_addr;
        n_wr++;
        mem[bus.acc_wr_addr] = bus.acc_wr_data;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s/wr_extra: got write addr 0x%0h, expected no write", cur_tag, bus.acc_wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.acc_wr_addr, e.addr);
          check("wr_data", bus.acc_wr_data, e.data);
        end
        if (chk_data_en) check("wr_const", bus.acc_wr_data, chk_data);
      end
      if (bus.done) begin
        n_done++;
        done_rel = edge_n + 1 - accept_edge;
      end
    end
  end

  task automatic drive_rows(input int gap);
    bit ok;
    rows_active = 1;
    for (int r = 0; r < M; r++) begin
      if (abort_rows) break;
      if (gap > 0) begin
        bus.row_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      for (int c = 0; c < N; c++) bus.row_data[c*W +: W] = lanes[r][c];
      bus.row_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (abort_rows) break;
        if (bus.row_ready) begin ok = 1; break; end
      end
      if (!ok) begin
        if (!abort_rows) check("row_timeout", 1, 0);
        break;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) bus.row_data[c*W +: W] = $urandom;
    end
    bus.row_valid = 1'b0;
    rows_active = 0;
  endtask

  task automatic issue_cmd(input bit accum, input logic [15:0] base);
    bit ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_accum = accum;
    bus.cmd_base  = base;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    accept_edge   = edge_n;
    bus.cmd_valid = 1'b0;
    bus.cmd_accum = $urandom_range(0, 1);
    bus.cmd_base  = 16'($urandom);
    check("ovf_clear_at_accept", bus.ovf, 0);
    check("busy_after_accept", bus.busy, 1);
  endtask

  task automatic clear_stats();
    n_wr = 0; n_rd = 0; n_done = 0; first_wr_rel = -1; done_rel = -1;
    wr8_addr = 16'hDEAD;
    exp_q.delete();
  endtask

  // Reference: element k of the tile goes to (base+k) mod 2^16; accumulate clamps to INT32.
  function automatic bit model_cmd(input bit accum, input logic [15:0] base, input int n_elem);
    bit m_ovf = 0;
    longint v;
    logic [15:0] a;
    for (int k = 0; k < n_elem; k++) begin
      a = base + 16'(k);
      if (accum) begin
        v = longint'(ref_mem[a]) + longint'(lanes[k / N][k % N]);
        if (v > 64'sd2147483647) begin v = 64'sd2147483647; m_ovf = 1; end
        else if (v < -64'sd2147483648) begin v = -64'sd2147483648; m_ovf = 1; end
        ref_mem[a] = 32'(v);
      end else begin
        ref_mem[a] = lanes[k / N][k % N];
      end
      exp_q.push_back('{addr: a, data: ref_mem[a]});
    end
    return m_ovf;
  endfunction

  task automatic run_cmd(input bit accum, input logic [15:0] base, input int gap, input int lat,
                         input bit stray, input int exp_done, input int exp_first, input int exp_ovf,
                         input bit cde, input logic [W-1:0] cdv, input bit wrap);
    bit m_ovf, ok;
    clear_stats();
    m_ovf = model_cmd(accum, base, M * N);
    rd_lat = lat; stray_en = stray; chk_data_en = cde; chk_data = cdv;
    fork drive_rows(gap); join_none
    issue_cmd(accum, base);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (n_done > 0) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 1, 0);
    check("idle_after_done", bus.cmd_ready, 1);
    check("busy_after_done", bus.busy, 0);
    repeat (2) @(posedge clk);
    #2;
    check("done_pulses", n_done, 1);
    check("n_writes", n_wr, M * N);
    check("n_reads", n_rd, accum ? M * N : 0);
    check("exp_left", exp_q.size(), 0);
    check("ovf", bus.ovf, (exp_ovf < 0) ? int'(m_ovf) : exp_ovf);
    check("rows_drained", rows_active, 0);
    if (exp_done >= 0) check("done_cycle", done_rel, exp_done);
    if (exp_first >= 0) check("first_wr_cycle", first_wr_rel, exp_first);
    if (wrap) check("wrap_addr_elem8", wr8_addr, 0);
    stray_en = 0; chk_data_en = 0;
  endtask

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit ok;
    bit r_acc;
    int r_gap, r_lat;
    logic [15:0] r_base;

    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_accum = 1'b0; bus.cmd_base = '0;
    bus.row_valid = 1'b0; bus.row_data = '0;
    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset";
    check("cmd_ready", bus.cmd_ready, 1);
    check("row_ready", bus.row_ready, 0);
    check("rd_en", bus.acc_rd_en, 0);
    check("wr_en", bus.acc_wr_en, 0);
    check("busy", bus.busy, 0);
    check("done", bus.done, 0);
    check("ovf", bus.ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //            acc  base      rc  val            gap lat stray done first ovf cde cdv           wrap
    vt[0] = '{1'b0, 16'h0000, 1'b1, 32'd0,          0, 1, 1'b1, 273,  2, 0, 1'b0, 32'd0,         1'b0};
    vt[1] = '{1'b0, 16'h1000, 1'b0, 32'd5,          0, 1, 1'b0, 273,  2, 0, 1'b1, 32'd5,         1'b0};
    vt[2] = '{1'b1, 16'h1000, 1'b0, 32'hFFFF_FFF9,  0, 1, 1'b0, 785,  4, 0, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vt[3] = '{1'b0, 16'h2000, 1'b0, 32'h7FFF_FFF0,  0, 1, 1'b1, 273,  2, 0, 1'b0, 32'd0,         1'b0};
    vt[4] = '{1'b1, 16'h2000, 1'b0, 32'h0000_0020,  0, 1, 1'b0, 785,  4, 1, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vt[5] = '{1'b0, 16'h3000, 1'b0, 32'h8000_0005,  0, 1, 1'b0, 273,  2, 0, 1'b1, 32'h8000_0005, 1'b0};
    vt[6] = '{1'b1, 16'h3000, 1'b0, 32'hFFFF_FF9C,  0, 1, 1'b0, 785,  4, 1, 1'b1, 32'h8000_0000, 1'b0};
    vt[7] = '{1'b1, 16'hFFF8, 1'b0, 32'd1,          5, 4, 1'b0,  -1, -1, 0, 1'b0, 32'd0,         1'b1};
    vt[8] = '{1'b1, 16'h4000, 1'b0, 32'd3,          0, 4, 1'b0, 1553, 7, 0, 1'b1, 32'd3,         1'b0};

    for (int t = 0; t < 9; t++) begin
      cur_tag = $sformatf("vec%0d", t);
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          lanes[r][c] = vt[t].pat_rc ? 32'(r * N + c) : vt[t].val;
      run_cmd(vt[t].accum, vt[t].base, vt[t].gap, vt[t].lat, vt[t].stray, vt[t].exp_done,
              vt[t].exp_first, vt[t].exp_ovf, vt[t].cde, vt[t].cdv, vt[t].wrap);
    end

    for (int p = 0; p < 4; p++) begin
      r_base = 16'($urandom);
      for (int s = 0; s < 2; s++) begin
        cur_tag = $sformatf("rand%0d_%0d", p, s);
        r_acc = (s == 1);
        r_gap = $urandom_range(0, 2);
        r_lat = $urandom_range(1, 3);
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++)
            lanes[r][c] = rand_lane();
        run_cmd(r_acc, r_base, r_gap, r_lat, !r_acc && ($urandom_range(0, 1) == 1),
                (r_gap == 0) ? (r_acc ? M * (N * (2 + r_lat) + 1) + 1 : M * (N + 1) + 1) : -1,
                (r_gap == 0) ? (r_acc ? 3 + r_lat : 2) : -1,
                -1, 1'b0, 32'd0, 1'b0);
      end
    end

    // Reset while row 3 is being written; the 53 writes up to row 3 col 4 are legitimate.
    cur_tag = "midreset";
    clear_stats();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        lanes[r][c] = 32'(16'h100 + r * N + c);
    void'(model_cmd(1'b0, 16'h5000, 3 * N + 5));
    rd_lat = 1;
    fork drive_rows(0); join_none
    issue_cmd(1'b0, 16'h5000);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (bus.acc_wr_en && bus.acc_wr_addr == 16'h5034) begin ok = 1; break; end
    end
    check("reach_row3", ok, 1);
    rst = 1'b1;
    abort_rows = 1;
    @(posedge clk);
    #1;
    check("cmd_ready", bus.cmd_ready, 1);
    check("busy", bus.busy, 0);
    check("rd_en", bus.acc_rd_en, 0);
    check("wr_en", bus.acc_wr_en, 0);
    check("row_ready", bus.row_ready, 0);
    check("done", bus.done, 0);
    rst = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (!rows_active) begin ok = 1; break; end
    end
    check("driver_stopped", ok, 1);
    check("writes_before_reset", n_wr, 3 * N + 5);
    check("exp_left", exp_q.size(), 0);
    check("no_done", n_done, 0);
    abort_rows = 0;

    cur_tag = "after_reset";
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        lanes[r][c] = 32'(r * N + c + 7);
    run_cmd(1'b0, 16'h6000, 0, 1, 1'b0, 273, 2, 0, 1'b0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
